// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - shared types, default timings and wrap helpers for cursor_ctrl
package cursor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    UP    = 2'd3
  } dir_t;

  localparam int unsigned DEF_DEBOUNCE_CYC = 500000;
  localparam int unsigned DEF_REPEAT_DLY   = 25000000;
  localparam int unsigned DEF_REPEAT_PER   = 5000000;

  // A zero-length interval would stall the counters, so it is treated as one cycle.
  function automatic logic [31:0] at_least_one(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

  function automatic logic [31:0] inc_wrap(input logic [31:0] x, input logic [31:0] lim);
    return (x == lim - 32'd1) ? 32'd0 : x + 32'd1;
  endfunction

  function automatic logic [31:0] dec_wrap(input logic [31:0] x, input logic [31:0] lim);
    return (x == 32'd0) ? lim - 32'd1 : x - 32'd1;
  endfunction

endpackage

// File: rtl/cursor_ctrl_if.sv
// rtl/cursor_ctrl_if.sv - key, grid and cursor-position bundle between board and cursor_ctrl
interface cursor_ctrl_if;

  logic [3:0]  key_n;
  logic [31:0] largeur_grille;
  logic [31:0] hauteur_grille;
  logic [31:0] h_position_du_curseur;
  logic [31:0] v_position_du_curseur;
  logic        move_pulse;

  modport master (
    output key_n,
    output largeur_grille,
    output hauteur_grille,
    input  h_position_du_curseur,
    input  v_position_du_curseur,
    input  move_pulse
  );

  modport slave (
    input  key_n,
    input  largeur_grille,
    input  hauteur_grille,
    output h_position_du_curseur,
    output v_position_du_curseur,
    output move_pulse
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer plus level debouncer for one active-low button
module key_debounce
  import cursor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_pressed
);

  localparam logic [31:0] LP_CYC = at_least_one(32'(DEBOUNCE_CYC));

  logic [1:0]  r_sync;
  logic        r_pressed;
  logic [31:0] r_cnt;
  logic        w_level;

  assign w_level   = ~r_sync[1];
  assign o_pressed = r_pressed;

  // The counter measures how long the synchronized level has disagreed with the accepted state.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= 2'b11;
      r_pressed <= 1'b0;
      r_cnt     <= 32'd0;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
      if (w_level == r_pressed) begin
        r_cnt <= 32'd0;
      end else if (r_cnt == LP_CYC - 32'd1) begin
        r_pressed <= w_level;
        r_cnt     <= 32'd0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - debounced 4-way cursor with auto-repeat and wrap/clamp on a WxH grid
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER
) (
  input  logic          clk_50,
  input  logic          reset_n,
  cursor_ctrl_if.slave  cur
);

  localparam logic [31:0] LP_DLY = at_least_one(32'(REPEAT_DLY));
  localparam logic [31:0] LP_PER = at_least_one(32'(REPEAT_PER));

  logic [3:0]  w_pressed;
  logic        w_valid;
  dir_t        w_dir;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_timer, w_timer_nxt;
  dir_t        r_dir, w_dir_nxt;
  logic        w_move;

  logic [31:0] r_h, r_v;
  logic        r_pulse;
  logic [31:0] w_w, w_hgt;
  logic        w_clamp;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk_50    (clk_50),
      .reset_n   (reset_n),
      .i_key_n   (cur.key_n[g]),
      .o_pressed (w_pressed[g])
    );
  end

  assign w_valid = $onehot(w_pressed);

  always_comb begin
    w_dir = RIGHT;
    case (w_pressed)
      4'b0010: w_dir = LEFT;
      4'b0100: w_dir = DOWN;
      4'b1000: w_dir = UP;
      default: w_dir = RIGHT;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_timer <= 32'd0;
      r_dir   <= RIGHT;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Any change of the held key set drops back to IDLE silently; IDLE re-arms on the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dir_nxt   = r_dir;
    w_move      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt = DELAY;
          w_timer_nxt = LP_DLY - 32'd1;
          w_dir_nxt   = w_dir;
          w_move      = 1'b1;
        end
      end
      DELAY, REPEAT: begin
        if (!w_valid || (w_dir != r_dir)) begin
          w_state_nxt = IDLE;
          w_timer_nxt = 32'd0;
        end else if (r_timer == 32'd0) begin
          w_state_nxt = REPEAT;
          w_timer_nxt = LP_PER - 32'd1;
          w_move      = 1'b1;
        end else begin
          w_timer_nxt = r_timer - 32'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = 32'd0;
      end
    endcase
  end

  assign w_w     = at_least_one(cur.largeur_grille);
  assign w_hgt   = at_least_one(cur.hauteur_grille);
  assign w_clamp = (r_h >= w_w) || (r_v >= w_hgt);

  // A shrinking grid pulls the cursor back inside before any move is honoured.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_h     <= 32'd0;
      r_v     <= 32'd0;
      r_pulse <= 1'b0;
    end else if (w_clamp) begin
      r_h     <= (r_h >= w_w)   ? w_w - 32'd1   : r_h;
      r_v     <= (r_v >= w_hgt) ? w_hgt - 32'd1 : r_v;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_move;
      if (w_move) begin
        case (w_dir_nxt)
          RIGHT:   r_h <= inc_wrap(r_h, w_w);
          LEFT:    r_h <= dec_wrap(r_h, w_w);
          DOWN:    r_v <= inc_wrap(r_v, w_hgt);
          UP:      r_v <= dec_wrap(r_v, w_hgt);
          default: r_h <= r_h;
        endcase
      end
    end
  end

  assign cur.h_position_du_curseur = r_h;
  assign cur.v_position_du_curseur = r_v;
  assign cur.move_pulse            = r_pulse;

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 500000, means stable-level cycles required to accept a key change (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DLY, default 25000000, means held-key cycles from first move to first auto-repeat (500 ms).
REQ-003 Parameter REPEAT_PER, default 5000000, means cycles between successive auto-repeat moves (100 ms).
REQ-004 Port clk_50, input, 1, is the single clock.
REQ-005 Port reset_n, input, 1, is the reset; one clock, reset asynchronous and active-low.
REQ-006 Port key_n, input, 4, carries raw asynchronous push-buttons, active-low: [0]=right, [1]=left, [2]=down, [3]=up.
REQ-007 Port largeur_grille, input, 32, is the grid width in cells.
REQ-008 Port hauteur_grille, input, 32, is the grid height in cells.
REQ-009 Port h_position_du_curseur, output, 32, is the cursor column, feeding vga_generator.
REQ-010 Port v_position_du_curseur, output, 32, is the cursor row, feeding vga_generator.
REQ-011 Port move_pulse, output, 1, is high for one cycle on every cycle a position update is applied.

Function
REQ-012 Each key_n bit SHALL pass a 2-flop synchronizer, then an independent debouncer; debounced state changes only after DEBOUNCE_CYC consecutive cycles at the new synchronized level.
REQ-013 Debounced keys SHALL be active-high internally: pressed = synchronized key_n low and stable.
REQ-014 Direction select: exactly one debounced key pressed selects its direction; zero or more than one pressed means "no key".
REQ-015 The repeat FSM SHALL have states IDLE, DELAY and REPEAT.
REQ-016 IDLE to DELAY on a valid key; issue one move that cycle; load the timer with REPEAT_DLY-1.
REQ-017 In DELAY, the timer decrements; at 0, go to REPEAT, issue one move, reload with REPEAT_PER-1.
REQ-018 In REPEAT, the timer decrements; at 0, issue one move and reload with REPEAT_PER-1.
REQ-019 From DELAY or REPEAT, "no key" or a direction different from the latched direction SHALL return to IDLE with no move that cycle; the next cycle re-evaluates from IDLE.
REQ-020 Moves are registered: the position and move_pulse update in the cycle after the FSM decision (latency 1 cycle from decision).
REQ-021 Right: h = (h == W-1) ? 0 : h+1. Left: h = (h == 0) ? W-1 : h-1. Down and up apply the same rules to v using H.
REQ-022 Effective W = max(largeur_grille, 1) and H = max(hauteur_grille, 1); all arithmetic is unsigned 32-bit.
REQ-023 Grid shrink: if h >= W (or v >= H), the position SHALL clamp to W-1 (or H-1) the next cycle without asserting move_pulse; the clamp takes priority over a move in the same cycle.
REQ-024 The timer is a 32-bit down-counter; a parameter value of 0 SHALL behave as 1.

Reset
REQ-025 While reset_n is low: h and v positions = 0, move_pulse = 0, FSM = IDLE, timer = 0, synchronizers = 1, debounced keys = released, debounce counters = 0.
REQ-026 Reset asserted mid-hold SHALL abort repeat; after release, a still-held key requires the full debounce before any move.

Structure
REQ-027 A shared package cursor_pkg SHALL hold the FSM state enumeration, the direction encoding (RIGHT, LEFT, DOWN, UP) and the default timing constants.
REQ-028 The per-key synchronizer plus debouncer SHALL be one sub-module, key_debounce, instantiated four times.

Verification
REQ-029 Scenario: sim with DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_PER=5 and W=H=8. Right key pressed 2 cycles then released -> no move. Held 30 cycles -> h=0 to 1 after debounce, then 2 at +20 cycles, 3 at +25, 4 at +30; one move_pulse each.
REQ-030 Scenario: h=0, single left press -> h=7. With v=7, single down press -> v=0 (wrap in both directions).
REQ-031 Scenario: up and left held together -> no move while both are held; release left -> up moves v once after debounce.
REQ-032 Scenario: h=6, largeur_grille changed 8 to 4 -> h=3 next cycle, move_pulse stays 0. largeur_grille=0 -> h=0 and right presses keep h=0.
REQ-033 Scenario: key held in REPEAT, reset_n pulsed low 3 cycles -> h=v=0 immediately. After release, the first move occurs only after 2+DEBOUNCE_CYC cycles.
REQ-034 Scenario: key bouncing (toggling every 2 cycles for 20 cycles, then stable low) -> exactly one move, DEBOUNCE_CYC+2 cycles after stable.
